// File: rtl/pasta_ks_pkg.sv
// pasta_ks_pkg: shared defaults, FSM state type and counter byte reversal for the Pasta keystream block
//   PASTA_S_DEF / BITLEN_DEF : default half-state geometry (elements, bits per element)
//   ks_state_t               : sequencer states
//   byte_reverse64           : reorders a 64-bit counter into the byte order the core expects
package pasta_ks_pkg;

    localparam int PASTA_S_DEF = 32;
    localparam int BITLEN_DEF  = 17;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        STALL,
        DRAIN,
        DONE
    } ks_state_t;

    function automatic logic [63:0] byte_reverse64(input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
        return r;
    endfunction

endpackage

// File: rtl/pasta_ks_fifo.sv
// pasta_ks_fifo: synchronous FIFO with flush, full/empty flags and simultaneous push/pop
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush         : empties the FIFO on the next edge, overriding push/pop
//   push, wdata   : write request and data (ignored when full)
//   pop           : read request (ignored when empty)
//   rdata         : head entry
//   full, empty   : occupancy flags
//   level         : current occupancy
module pasta_ks_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int AW   = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= do_push ? bump(wr_ptr) : wr_ptr;
            rd_ptr <= do_pop ? bump(rd_ptr) : rd_ptr;
            level  <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage needs no reset: the head is only visible while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cipher_pasta_keystream.sv
// cipher_pasta_keystream: sequences an external Pasta permutation core over NUM_BLOCKS counters and streams keystream
//   Clk_CI, Rst_RBI           : clock, asynchronous active-low reset
//   Start_SI                  : start pulse, sampled in IDLE only
//   Nonce_DI, Key_DI          : nonce and key {key_l, key_r}, latched at Start
//   CounterInit_DI            : first block counter, latched at Start
//   NumBlocks_DI              : number of blocks to generate, latched at Start
//   Busy_SO, Finish_SO        : run in progress / one-cycle completion pulse
//   KsData_DO, KsValid_SO,
//   KsReady_SI                : keystream stream port, pop on valid & ready
//   PpInit_SO                 : core run enable (low holds the core in reset)
//   PpNonce_DO, PpCounter_DO,
//   PpKeyL_DO, PpKeyR_DO      : core inputs (counter is byte-reversed)
//   PpDone_SI, PpOutL_DI      : core done level and left-half output
//   Abort_SI                  : present only when CIPHER_KS_ABORT_EN is defined; cancels the run
module cipher_pasta_keystream
    import pasta_ks_pkg::*;
#(
    parameter int PASTA_S    = PASTA_S_DEF,
    parameter int BITLEN     = BITLEN_DEF,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16,
    localparam int HW        = PASTA_S * BITLEN,
    localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            Clk_CI,
    input  logic            Rst_RBI,
    input  logic            Start_SI,
    input  logic [63:0]     Nonce_DI,
    input  logic [2*HW-1:0] Key_DI,
    input  logic [63:0]     CounterInit_DI,
    input  logic [CNT_W-1:0] NumBlocks_DI,
    output logic            Busy_SO,
    output logic            Finish_SO,
    output logic [HW-1:0]   KsData_DO,
    output logic            KsValid_SO,
    input  logic            KsReady_SI,
    output logic            PpInit_SO,
    output logic [63:0]     PpNonce_DO,
    output logic [63:0]     PpCounter_DO,
    output logic [HW-1:0]   PpKeyL_DO,
    output logic [HW-1:0]   PpKeyR_DO,
    input  logic            PpDone_SI,
    input  logic [HW-1:0]   PpOutL_DI
`ifdef CIPHER_KS_ABORT_EN
    ,
    input  logic            Abort_SI
`endif
);

    ks_state_t        state;
    ks_state_t        nxt;
    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [63:0]      cur_cnt;
    logic [CNT_W-1:0] remaining;
    logic             abort;
    logic             push;
    logic             pop;
    logic             slot_after_push;
    logic [HW-1:0]    fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LW-1:0]    fifo_level;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

`ifdef CIPHER_KS_ABORT_EN
    assign abort = Abort_SI && state != IDLE && state != DONE;
`else
    assign abort = 1'b0;
`endif

    assign pop             = KsValid_SO && KsReady_SI;
    // Occupancy after this cycle's push, net of a concurrent pop.
    assign slot_after_push = int'(fifo_level) + 1 - int'(pop) < FIFO_DEPTH;

    always_ff @(posedge Clk_CI or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !Start_SI ? IDLE : NumBlocks_DI == '0 ? DONE : LOAD;
            LOAD:    nxt = RUN;
            RUN:     nxt = PpDone_SI ? CAPTURE : RUN;
            CAPTURE: nxt = remaining == CNT_W'(1) ? DRAIN : slot_after_push ? LOAD : STALL;
            STALL:   nxt = fifo_full ? STALL : LOAD;
            DRAIN:   nxt = fifo_empty ? DONE : DRAIN;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort) nxt = DONE;
    end

    always_comb begin
        PpInit_SO = state == RUN && !abort;
        Busy_SO   = state != IDLE && state != DONE;
        Finish_SO = state == DONE;
        push      = state == CAPTURE && !abort;
    end

    always_ff @(posedge Clk_CI or negedge rst_n) begin
        if (!rst_n) begin
            PpNonce_DO   <= '0;
            PpKeyL_DO    <= '0;
            PpKeyR_DO    <= '0;
            PpCounter_DO <= '0;
            cur_cnt      <= '0;
            remaining    <= '0;
        end else begin
            if (state == IDLE && Start_SI) begin
                PpNonce_DO <= Nonce_DI;
                PpKeyL_DO  <= Key_DI[2*HW-1:HW];
                PpKeyR_DO  <= Key_DI[HW-1:0];
                cur_cnt    <= CounterInit_DI;
                remaining  <= NumBlocks_DI;
            end
            if (state == LOAD) PpCounter_DO <= byte_reverse64(cur_cnt);
            if (state == CAPTURE) begin
                cur_cnt   <= cur_cnt + 64'd1;
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    pasta_ks_fifo #(
        .W     (HW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk_CI),
        .rst_n (rst_n),
        .flush (abort),
        .push  (push),
        .wdata (PpOutL_DI),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign KsValid_SO = !fifo_empty;
    assign KsData_DO  = KsValid_SO ? fifo_head : '0;

endmodule

// File: tb/tb_cipher_pasta_keystream.sv
// tb_cipher_pasta_keystream: scoreboard bench for cipher_pasta_keystream with a stub permutation core
module tb_cipher_pasta_keystream;

    localparam int HW  = 32 * 17;
    localparam int LAT = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [63:0]     nonce;
    logic [2*HW-1:0] key;
    logic [63:0]     cnt_in;
    logic [15:0]     nb;
    logic            busy;
    logic            finish;
    logic [HW-1:0]   ks_data;
    logic            ks_valid;
    logic            ready;
    logic            pp_init;
    logic [63:0]     pp_nonce;
    logic [63:0]     pp_counter;
    logic [HW-1:0]   pp_key_l;
    logic [HW-1:0]   pp_key_r;
    logic            pp_done;
    logic [HW-1:0]   pp_out;
`ifdef CIPHER_KS_ABORT_EN
    logic            abort;
`endif

    logic [63:0]   ctr_q[$];
    logic [HW-1:0] dat_q[$];
    int n_vec = 0;
    int n_err = 0;
    int launches = 0;
    int beats = 0;
    int fin_cnt = 0;
    int valid_cyc = 0;
    int run = 0;
    logic prev_init = 1'b0;

    always #5 clk = ~clk;

    cipher_pasta_keystream dut (
        .Clk_CI         (clk),
        .Rst_RBI        (rst_n),
        .Start_SI       (start),
        .Nonce_DI       (nonce),
        .Key_DI         (key),
        .CounterInit_DI (cnt_in),
        .NumBlocks_DI   (nb),
        .Busy_SO        (busy),
        .Finish_SO      (finish),
        .KsData_DO      (ks_data),
        .KsValid_SO     (ks_valid),
        .KsReady_SI     (ready),
        .PpInit_SO      (pp_init),
        .PpNonce_DO     (pp_nonce),
        .PpCounter_DO   (pp_counter),
        .PpKeyL_DO      (pp_key_l),
        .PpKeyR_DO      (pp_key_r),
        .PpDone_SI      (pp_done),
        .PpOutL_DI      (pp_out)
`ifdef CIPHER_KS_ABORT_EN
        ,
        .Abort_SI       (abort)
`endif
    );

    function automatic logic [63:0] brev(input logic [63:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24], v[39:32], v[47:40], v[55:48], v[63:56]};
    endfunction

    function automatic logic [HW-1:0] ks(input logic [63:0] c);
        logic [9*64-1:0] w;
        w = {9{c ^ 64'hA5A5_A5A5_A5A5_A5A5}};
        return w[HW-1:0];
    endfunction

    task automatic check(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stub core: done rises LAT cycles after run enable and holds until enable drops.
    always @(posedge clk) begin
        if (!rst_n || !pp_init) begin
            run     <= 0;
            pp_done <= 1'b0;
        end else if (run == LAT - 1) pp_done <= 1'b1;
        else run <= run + 1;
    end

    assign pp_out = pp_done ? ks(pp_counter) : '0;

    always @(negedge clk) begin
        if (!rst_n) prev_init <= 1'b0;
        else begin
            prev_init <= pp_init;
            if (pp_init && !prev_init) begin
                launches <= launches + 1;
                check("launch_expected", HW'(ctr_q.size() > 0), HW'(1));
                if (ctr_q.size() > 0) check("pp_counter", HW'(pp_counter), HW'(ctr_q.pop_front()));
            end
            if (ks_valid && ready) begin
                beats <= beats + 1;
                check("beat_expected", HW'(dat_q.size() > 0), HW'(1));
                if (dat_q.size() > 0) check("ks_data", ks_data, dat_q.pop_front());
            end
            if (finish) fin_cnt <= fin_cnt + 1;
            if (ks_valid) valid_cyc <= valid_cyc + 1;
        end
    end

    task automatic start_run(input logic [63:0] c, input int n);
        logic [63:0] x;
        x = c;
        for (int i = 0; i < n; i++) begin
            ctr_q.push_back(brev(x));
            dat_q.push_back(ks(brev(x)));
            x = x + 64'd1;
        end
        @(posedge clk); #1;
        start  = 1'b1;
        cnt_in = c;
        nb     = 16'(n);
        @(posedge clk); #1;
        start  = 1'b0;
        cnt_in = 64'hDEAD_BEEF_0BAD_F00D;
        nb     = 16'h7;
    endtask

    task automatic wait_finish(input string tag, input int budget);
        int f0;
        int k;
        f0 = fin_cnt;
        k  = 0;
        while (fin_cnt == f0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(tag, HW'(fin_cnt != f0), HW'(1));
    endtask

    task automatic wait_launch(input int target);
        int k;
        k = 0;
        while (launches < target && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("launch_wait", HW'(launches >= target), HW'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int l0;
        int b0;
        int v0;
        int f0;
        int k;
        logic [63:0]     n_save;
        logic [2*HW-1:0] k_save;
        rst_n  = 1'b0;
        start  = 1'b0;
        ready  = 1'b1;
        nonce  = 64'h0;
        key    = '0;
        cnt_in = 64'h0;
        nb     = 16'h0;
`ifdef CIPHER_KS_ABORT_EN
        abort  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", HW'(busy), HW'(0));
        check("rst_finish", HW'(finish), HW'(0));
        check("rst_valid", HW'(ks_valid), HW'(0));
        check("rst_data", ks_data, HW'(0));
        check("rst_init", HW'(pp_init), HW'(0));
        check("rst_counter", HW'(pp_counter), HW'(0));
        check("rst_nonce", HW'(pp_nonce), HW'(0));
        check("rst_keyl", pp_key_l, HW'(0));
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        nonce  = 64'h0123_4567_89AB_CDEF;
        key    = {{17{32'hCAFE_F00D}}, {17{32'h1234_5678}}};
        n_save = nonce;
        k_save = key;
        b0 = beats;
        start_run(64'h1, 1);
        nonce = ~nonce;
        key   = ~key;
        @(posedge clk); #1;
        check("busy_running", HW'(busy), HW'(1));
        check("latched_nonce", HW'(pp_nonce), HW'(n_save));
        check("latched_keyl", pp_key_l, k_save[2*HW-1:HW]);
        check("latched_keyr", pp_key_r, k_save[HW-1:0]);
        wait_finish("fin_single", 100);
        check("ctr_single", HW'(pp_counter), HW'(64'h0100_0000_0000_0000));
        check("beats_single", HW'(beats - b0), HW'(1));
        check("busy_after", HW'(busy), HW'(0));

        l0 = launches;
        b0 = beats;
        start_run(64'd5, 4);
        repeat (5) @(posedge clk);
        #1;
        start  = 1'b1;
        cnt_in = 64'd999;
        nb     = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_finish("fin_four", 400);
        check("launches_four", HW'(launches - l0), HW'(4));
        check("beats_four", HW'(beats - b0), HW'(4));
        check("ctr_last_four", HW'(pp_counter), HW'(64'h0800_0000_0000_0000));

        ready = 1'b0;
        l0 = launches;
        b0 = beats;
        start_run(64'd100, 5);
        repeat (200) @(posedge clk);
        #1;
        check("bp_launches", HW'(launches - l0), HW'(2));
        check("bp_valid", HW'(ks_valid), HW'(1));
        check("bp_init", HW'(pp_init), HW'(0));
        check("bp_busy", HW'(busy), HW'(1));
        check("bp_beats", HW'(beats - b0), HW'(0));
        ready = 1'b1;
        wait_finish("fin_bp", 600);
        check("bp_beats_all", HW'(beats - b0), HW'(5));
        check("bp_q_empty", HW'(dat_q.size()), HW'(0));

        start_run(64'hFFFF_FFFF_FFFF_FFFF, 2);
        wait_finish("fin_wrap", 200);
        check("ctr_wrap", HW'(pp_counter), HW'(0));

        b0 = beats;
        start_run({$urandom, $urandom}, 6);
        f0 = fin_cnt;
        k  = 0;
        while (fin_cnt == f0 && k < 2000) begin
            @(posedge clk); #1;
            ready = 1'($urandom_range(0, 1));
            k++;
        end
        ready = 1'b1;
        check("fin_random", HW'(fin_cnt != f0), HW'(1));
        check("beats_random", HW'(beats - b0), HW'(6));

        l0 = launches;
        v0 = valid_cyc;
        start_run(64'd77, 0);
        wait_finish("fin_zero", 6);
        check("zero_launches", HW'(launches - l0), HW'(0));
        check("zero_valid", HW'(valid_cyc - v0), HW'(0));

`ifdef CIPHER_KS_ABORT_EN
        ready = 1'b0;
        start_run(64'h200, 4);
        repeat (40) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_init", HW'(pp_init), HW'(0));
        wait_finish("fin_abort", 5);
        check("abort_valid", HW'(ks_valid), HW'(0));
        ctr_q.delete();
        dat_q.delete();
        ready = 1'b1;
`endif

        l0 = launches;
        start_run(64'h40, 3);
        wait_launch(l0 + 2);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_init", HW'(pp_init), HW'(0));
        check("arst_busy", HW'(busy), HW'(0));
        check("arst_valid", HW'(ks_valid), HW'(0));
        check("arst_data", ks_data, HW'(0));
        check("arst_counter", HW'(pp_counter), HW'(0));
        check("arst_finish", HW'(finish), HW'(0));
        ctr_q.delete();
        dat_q.delete();
        f0 = fin_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("arst_no_finish", HW'(fin_cnt - f0), HW'(0));
        check("arst_valid_after", HW'(ks_valid), HW'(0));
        check("arst_busy_after", HW'(busy), HW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
